// File: rtl/tcam_filter_lookup_pkg.sv
// Shared defaults and types for the ternary packet-filter lookup.
package filter_pkg;
  localparam int DEF_TUPLE_WIDTH = 104;
  localparam int DEF_NUM_QUEUES  = 8;
  localparam int DEF_DEPTH_BITS  = 5;
  localparam int DEF_CNT_WIDTH   = 32;
  localparam int LUT_DEPTH       = 2**DEF_DEPTH_BITS;
  // rule + mask + action bits per entry; valid and counter live beside it
  localparam int LUT_ENTRY_W     = 2*DEF_TUPLE_WIDTH + DEF_NUM_QUEUES;

  typedef logic [LUT_DEPTH-1:0]      match_vec_t;
  typedef logic [DEF_NUM_QUEUES-1:0] action_t;
endpackage

// File: rtl/tcam_filter_lookup_prio_enc.sv
// Lowest-set-bit priority encoder: index of bit 0-most hit plus any-hit flag.
module prio_enc_lsb #(
  parameter int N  = 32,
  parameter int IW = 5
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    for (int i = N-1; i >= 0; i--)
      if (vec[i]) idx = IW'(i);
  end

  assign any = |vec;
endmodule

// File: rtl/tcam_filter_lookup.sv
// Two-stage ternary rule lookup with per-rule action, valid bit and saturating hit counter.
module tcam_filter_lookup
  import filter_pkg::*;
#(
  parameter int TUPLE_WIDTH        = DEF_TUPLE_WIDTH,
  parameter int NUM_QUEUES         = DEF_NUM_QUEUES,
  parameter int MON_LUT_DEPTH_BITS = DEF_DEPTH_BITS,
  parameter int CNT_WIDTH          = DEF_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [TUPLE_WIDTH-1:0]        tuple,
  input  logic                          lookup_req,
  input  logic [NUM_QUEUES-1:0]         miss_ports,
  output logic [NUM_QUEUES-1:0]         dst_ports,
  output logic                          lookup_done,
  output logic                          match_hit,
  output logic [MON_LUT_DEPTH_BITS-1:0] match_idx,
  input  logic                          rule_wr_req,
  input  logic [MON_LUT_DEPTH_BITS-1:0] rule_wr_addr,
  input  logic [TUPLE_WIDTH-1:0]        rule_wr,
  input  logic [TUPLE_WIDTH-1:0]        rule_wr_mask,
  input  logic [NUM_QUEUES-1:0]         rule_wr_ports,
  input  logic                          rule_wr_valid,
  output logic                          rule_wr_ack,
  input  logic                          rule_rd_req,
  input  logic                          rule_rd_clr,
  input  logic [MON_LUT_DEPTH_BITS-1:0] rule_rd_addr,
  output logic [TUPLE_WIDTH-1:0]        rule_rd,
  output logic [TUPLE_WIDTH-1:0]        rule_rd_mask,
  output logic [NUM_QUEUES-1:0]         rule_rd_ports,
  output logic                          rule_rd_valid,
  output logic [CNT_WIDTH-1:0]          rule_rd_cnt,
  output logic                          rule_rd_ack
);
  localparam int DEPTH = 2**MON_LUT_DEPTH_BITS;
  localparam int AW    = MON_LUT_DEPTH_BITS;

  logic [TUPLE_WIDTH-1:0] rule_q  [DEPTH];
  logic [TUPLE_WIDTH-1:0] mask_q  [DEPTH];
  logic [NUM_QUEUES-1:0]  ports_q [DEPTH];
  logic [DEPTH-1:0]       valid_q;
  logic [DEPTH-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [DEPTH-1:0]      match, match_q;
  logic [2:1]            vld_pipe;
  logic [AW-1:0]         hit_idx;
  logic                  hit_any, hit;
  logic                  byp_vld;
  logic [AW-1:0]         byp_addr;
  logic [NUM_QUEUES-1:0] byp_ports;
  logic                  rd_pend, rd_clr_q;
  logic [AW-1:0]         rd_addr_q;

  assign lookup_done = vld_pipe[2];
  assign hit         = vld_pipe[1] & hit_any;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic          zero;
    logic [CNT_WIDTH-1:0] base;
    assign match[g] = valid_q[g] && (((tuple ^ rule_q[g]) & ~mask_q[g]) == '0);
    // clear first, then apply a same-cycle hit so the hit is never lost
    assign zero     = (rule_wr_req && rule_wr_addr == AW'(g)) ||
                      (rd_pend && rd_clr_q && rd_addr_q == AW'(g));
    assign base     = zero ? '0 : cnt_q[g];
    assign cnt_d[g] = (hit && hit_idx == AW'(g) && !(&base)) ? base + 1'b1 : base;
  end

  prio_enc_lsb #(.N(DEPTH), .IW(AW)) u_enc (
    .vec (match_q),
    .idx (hit_idx),
    .any (hit_any)
  );

  always_ff @(posedge clk) begin
    if (rule_wr_req) begin
      rule_q[rule_wr_addr]  <= rule_wr;
      mask_q[rule_wr_addr]  <= rule_wr_mask;
      ports_q[rule_wr_addr] <= rule_wr_ports;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q       <= '0;
      cnt_q         <= '0;
      match_q       <= '0;
      vld_pipe      <= '0;
      byp_vld       <= 1'b0;
      byp_addr      <= '0;
      byp_ports     <= '0;
      dst_ports     <= '0;
      match_hit     <= 1'b0;
      match_idx     <= '0;
      rule_wr_ack   <= 1'b0;
      rd_pend       <= 1'b0;
      rd_clr_q      <= 1'b0;
      rd_addr_q     <= '0;
      rule_rd_ack   <= 1'b0;
      rule_rd       <= '0;
      rule_rd_mask  <= '0;
      rule_rd_ports <= '0;
      rule_rd_valid <= 1'b0;
      rule_rd_cnt   <= '0;
    end else begin
      if (rule_wr_req) valid_q[rule_wr_addr] <= rule_wr_valid;
      cnt_q    <= cnt_d;
      match_q  <= match;
      vld_pipe <= {vld_pipe[1], lookup_req};
      // old action of an entry rewritten while its lookup sits in stage 1
      byp_vld   <= rule_wr_req;
      byp_addr  <= rule_wr_addr;
      byp_ports <= ports_q[rule_wr_addr];
      if (vld_pipe[1]) begin
        match_hit <= hit_any;
        match_idx <= hit_any ? hit_idx : '0;
        if (!hit_any)                            dst_ports <= miss_ports;
        else if (byp_vld && byp_addr == hit_idx) dst_ports <= byp_ports;
        else                                     dst_ports <= ports_q[hit_idx];
      end
      rule_wr_ack <= rule_wr_req;
      rd_pend     <= rule_rd_req;
      rd_clr_q    <= rule_rd_clr;
      rd_addr_q   <= rule_rd_addr;
      rule_rd_ack <= rd_pend;
      if (rd_pend) begin
        rule_rd       <= rule_q[rd_addr_q];
        rule_rd_mask  <= mask_q[rd_addr_q];
        rule_rd_ports <= ports_q[rd_addr_q];
        rule_rd_valid <= valid_q[rd_addr_q];
        rule_rd_cnt   <= cnt_q[rd_addr_q];
      end
    end
  end
endmodule

// File: tb/tb_tcam_filter_lookup.sv
// Directed bench for tcam_filter_lookup: transaction-level model plus literal spot checks.
module tb_tcam_filter_lookup;
  localparam int TW = 104, NQ = 8, AB = 5, D = 32;

  logic clk = 1'b0, resetn = 1'b0;
  logic [TW-1:0] tuple = '0;
  logic          lookup_req = 1'b0;
  logic [NQ-1:0] miss_ports = 8'h10;
  logic          rule_wr_req = 1'b0, rule_wr_valid = 1'b0;
  logic [AB-1:0] rule_wr_addr = '0, rule_rd_addr = '0;
  logic [TW-1:0] rule_wr = '0, rule_wr_mask = '0;
  logic [NQ-1:0] rule_wr_ports = '0;
  logic          rule_rd_req = 1'b0, rule_rd_clr = 1'b0;

  logic [NQ-1:0] dst_ports, s_dst_ports, rule_rd_ports, s_rule_rd_ports;
  logic          lookup_done, match_hit, rule_wr_ack, rule_rd_valid, rule_rd_ack;
  logic          s_lookup_done, s_match_hit, s_rule_wr_ack, s_rule_rd_valid, s_rule_rd_ack;
  logic [AB-1:0] match_idx, s_match_idx;
  logic [TW-1:0] rule_rd, rule_rd_mask, s_rule_rd, s_rule_rd_mask;
  logic [31:0]   rule_rd_cnt;
  logic [3:0]    s_rule_rd_cnt;

  tcam_filter_lookup dut (
    .clk(clk), .resetn(resetn), .tuple(tuple), .lookup_req(lookup_req), .miss_ports(miss_ports),
    .dst_ports(dst_ports), .lookup_done(lookup_done), .match_hit(match_hit), .match_idx(match_idx),
    .rule_wr_req(rule_wr_req), .rule_wr_addr(rule_wr_addr), .rule_wr(rule_wr),
    .rule_wr_mask(rule_wr_mask), .rule_wr_ports(rule_wr_ports), .rule_wr_valid(rule_wr_valid),
    .rule_wr_ack(rule_wr_ack), .rule_rd_req(rule_rd_req), .rule_rd_clr(rule_rd_clr),
    .rule_rd_addr(rule_rd_addr), .rule_rd(rule_rd), .rule_rd_mask(rule_rd_mask),
    .rule_rd_ports(rule_rd_ports), .rule_rd_valid(rule_rd_valid), .rule_rd_cnt(rule_rd_cnt),
    .rule_rd_ack(rule_rd_ack)
  );

  // narrow-counter build to reach saturation in a few hits
  tcam_filter_lookup #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .resetn(resetn), .tuple(tuple), .lookup_req(lookup_req), .miss_ports(miss_ports),
    .dst_ports(s_dst_ports), .lookup_done(s_lookup_done), .match_hit(s_match_hit),
    .match_idx(s_match_idx), .rule_wr_req(rule_wr_req), .rule_wr_addr(rule_wr_addr),
    .rule_wr(rule_wr), .rule_wr_mask(rule_wr_mask), .rule_wr_ports(rule_wr_ports),
    .rule_wr_valid(rule_wr_valid), .rule_wr_ack(s_rule_wr_ack), .rule_rd_req(rule_rd_req),
    .rule_rd_clr(rule_rd_clr), .rule_rd_addr(rule_rd_addr), .rule_rd(s_rule_rd),
    .rule_rd_mask(s_rule_rd_mask), .rule_rd_ports(s_rule_rd_ports),
    .rule_rd_valid(s_rule_rd_valid), .rule_rd_cnt(s_rule_rd_cnt), .rule_rd_ack(s_rule_rd_ack)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [TW-1:0] m_rule [D];
  logic [TW-1:0] m_mask [D];
  logic [NQ-1:0] m_ports [D];
  bit            m_valid [D];
  bit            m_known [D];
  longint        m_cnt [D];
  int            m_cnt4 [D];

  bit            pl_vld = 0, pl_hit = 0;
  int            pl_idx = 0;
  logic [NQ-1:0] pl_ports = '0;
  bit            pr_vld = 0, pr_clr = 0;
  int            pr_addr = 0;

  logic [NQ-1:0] e_dst = '0, e_rd_ports = '0;
  bit            e_done = 0, e_hit = 0, e_wr_ack = 0, e_rd_ack = 0, e_rd_valid = 0, e_rd_known = 1;
  int            e_idx = 0, e_rd_cnt4 = 0;
  longint        e_rd_cnt = 0;
  logic [TW-1:0] e_rd_rule = '0, e_rd_mask = '0;

  function automatic int winner(input logic [TW-1:0] t);
    for (int i = 0; i < D; i++)
      if (m_valid[i] && ((t ^ m_rule[i]) & ~m_mask[i]) == '0) return i;
    return -1;
  endfunction

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      for (int i = 0; i < D; i++) begin m_valid[i] = 0; m_cnt[i] = 0; m_cnt4[i] = 0; end
      pl_vld = 0; pr_vld = 0;
      e_dst = '0; e_done = 0; e_hit = 0; e_idx = 0; e_wr_ack = 0; e_rd_ack = 0;
      e_rd_rule = '0; e_rd_mask = '0; e_rd_ports = '0; e_rd_valid = 0;
      e_rd_cnt = 0; e_rd_cnt4 = 0; e_rd_known = 1;
    end else begin
      int hidx, w;
      // results of the lookup issued on the previous edge
      e_done = pl_vld;
      hidx = -1;
      if (pl_vld) begin
        e_hit = pl_hit;
        e_idx = pl_hit ? pl_idx : 0;
        e_dst = pl_hit ? pl_ports : miss_ports;
        if (pl_hit) hidx = pl_idx;
      end
      e_rd_ack = pr_vld;
      if (pr_vld) begin
        e_rd_rule = m_rule[pr_addr]; e_rd_mask = m_mask[pr_addr]; e_rd_ports = m_ports[pr_addr];
        e_rd_valid = m_valid[pr_addr]; e_rd_known = m_known[pr_addr];
        e_rd_cnt = m_cnt[pr_addr]; e_rd_cnt4 = m_cnt4[pr_addr];
        if (pr_clr) begin m_cnt[pr_addr] = 0; m_cnt4[pr_addr] = 0; end
      end
      if (rule_wr_req) begin m_cnt[rule_wr_addr] = 0; m_cnt4[rule_wr_addr] = 0; end
      if (hidx >= 0) begin
        if (m_cnt[hidx] < 64'hFFFF_FFFF) m_cnt[hidx]++;
        if (m_cnt4[hidx] < 15) m_cnt4[hidx]++;
      end
      // a new lookup sees the table as it stood before this edge's write
      pl_vld = lookup_req;
      if (lookup_req) begin
        w = winner(tuple);
        pl_hit = (w >= 0);
        pl_idx = w;
        pl_ports = (w >= 0) ? m_ports[w] : '0;
      end
      e_wr_ack = rule_wr_req;
      if (rule_wr_req) begin
        m_rule[rule_wr_addr] = rule_wr; m_mask[rule_wr_addr] = rule_wr_mask;
        m_ports[rule_wr_addr] = rule_wr_ports; m_valid[rule_wr_addr] = rule_wr_valid;
        m_known[rule_wr_addr] = 1;
      end
      pr_vld = rule_rd_req; pr_clr = rule_rd_clr; pr_addr = int'(rule_rd_addr);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(posedge clk);
    #2;
    chk("done", lookup_done, e_done);     chk("done4", s_lookup_done, e_done);
    chk("dst", dst_ports, e_dst);         chk("dst4", s_dst_ports, e_dst);
    chk("hit", match_hit, e_hit);         chk("hit4", s_match_hit, e_hit);
    chk("idx", match_idx, e_idx);         chk("idx4", s_match_idx, e_idx);
    chk("wr_ack", rule_wr_ack, e_wr_ack); chk("wr_ack4", s_rule_wr_ack, e_wr_ack);
    chk("rd_ack", rule_rd_ack, e_rd_ack); chk("rd_ack4", s_rule_rd_ack, e_rd_ack);
    chk("rd_valid", rule_rd_valid, e_rd_valid); chk("rd_valid4", s_rule_rd_valid, e_rd_valid);
    chk("rd_cnt", rule_rd_cnt, e_rd_cnt); chk("rd_cnt4", s_rule_rd_cnt, e_rd_cnt4);
    if (e_rd_known) begin
      chk("rd_rule", rule_rd, e_rd_rule);        chk("rd_rule4", s_rule_rd, e_rd_rule);
      chk("rd_mask", rule_rd_mask, e_rd_mask);   chk("rd_mask4", s_rule_rd_mask, e_rd_mask);
      chk("rd_ports", rule_rd_ports, e_rd_ports); chk("rd_ports4", s_rule_rd_ports, e_rd_ports);
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic wr(input int a, input logic [TW-1:0] r, input logic [TW-1:0] m,
                    input logic [NQ-1:0] p, input bit v);
    @(negedge clk);
    rule_wr_req = 1; rule_wr_addr = AB'(a); rule_wr = r; rule_wr_mask = m;
    rule_wr_ports = p; rule_wr_valid = v;
    @(negedge clk);
    rule_wr_req = 0;
    chk("lit_wr_ack", rule_wr_ack, 1);
  endtask

  task automatic lk(input logic [TW-1:0] t, input logic [NQ-1:0] ep, input int ei, input bit eh);
    @(negedge clk); tuple = t; lookup_req = 1;
    @(negedge clk); lookup_req = 0;
    chk("lit_lk_latency", lookup_done, 0);
    @(negedge clk);
    chk("lit_lk_done", lookup_done, 1);
    chk("lit_lk_dst", dst_ports, ep);
    chk("lit_lk_idx", match_idx, ei);
    chk("lit_lk_hit", match_hit, eh);
  endtask

  task automatic rd(input int a, input bit c, input longint ec, input int ec4, input bit ev);
    @(negedge clk); rule_rd_req = 1; rule_rd_clr = c; rule_rd_addr = AB'(a);
    @(negedge clk); rule_rd_req = 0; rule_rd_clr = 0;
    @(negedge clk);
    chk("lit_rd_ack", rule_rd_ack, 1);
    chk("lit_rd_cnt", rule_rd_cnt, ec);
    chk("lit_rd_cnt4", s_rule_rd_cnt, ec4);
    chk("lit_rd_valid", rule_rd_valid, ev);
  endtask

  initial begin
    logic [TW-1:0] ones, abcd;
    int n;
    ones = '1;
    abcd = 104'hABCD;
    repeat (3) @(negedge clk);
    resetn = 1;

    // empty table: everything misses
    lk('0, 8'h10, 0, 0);
    lk(ones, 8'h10, 0, 0);
    rd(3, 0, 0, 0, 0);
    rd(7, 0, 0, 0, 0);

    // exact rule 3, catch-all rule 7
    wr(3, abcd, '0, 8'h02, 1);
    wr(7, '0, ones, 8'h80, 1);
    lk(abcd, 8'h02, 3, 1);
    lk(104'h1234, 8'h80, 7, 1);

    // back-to-back burst and counter read/clear
    rd(3, 1, 1, 1, 1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (lookup_done) n++;
      tuple = abcd; lookup_req = (i < 5);
    end
    lookup_req = 0;
    chk("lit_burst_pulses", n, 5);
    rd(3, 0, 5, 5, 1);
    rd(3, 1, 5, 5, 1);
    rd(3, 0, 0, 0, 1);

    // write colliding with a lookup on the same entry
    @(negedge clk);
    tuple = abcd; lookup_req = 1;
    rule_wr_req = 1; rule_wr_addr = 5'd3; rule_wr = 104'h1234; rule_wr_mask = '0;
    rule_wr_ports = 8'h04; rule_wr_valid = 1;
    @(negedge clk); rule_wr_req = 0;
    @(negedge clk); lookup_req = 0;
    chk("lit_coll_old_dst", dst_ports, 8'h02);
    chk("lit_coll_old_idx", match_idx, 3);
    @(negedge clk);
    chk("lit_coll_new_dst", dst_ports, 8'h80);
    chk("lit_coll_new_idx", match_idx, 7);
    rd(3, 0, 1, 1, 1);

    // saturation of the narrow counter
    rd(7, 1, 2, 2, 1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); tuple = 104'h5555; lookup_req = 1;
    end
    @(negedge clk); lookup_req = 0;
    repeat (2) @(negedge clk);
    rd(7, 0, 16, 15, 1);

    // reset with lookups in flight
    @(negedge clk); tuple = abcd; lookup_req = 1;
    @(negedge clk); resetn = 0; lookup_req = 0;
    n = 0;
    repeat (3) begin
      #2;
      if (lookup_done) n++;
      chk("lit_rst_dst", dst_ports, 0);
      chk("lit_rst_idx", match_idx, 0);
      chk("lit_rst_rd_valid", rule_rd_valid, 0);
      @(negedge clk);
    end
    resetn = 1;
    repeat (3) begin
      @(negedge clk);
      if (lookup_done) n++;
    end
    chk("lit_rst_no_done", n, 0);
    rd(3, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
